acid_bus_capture: RTL and testbench

Front end of the cartridge ACID emulation. It watches the asynchronous Z80 expansion bus and captures every I/O write to the CRTC select port (&BCxx). Each captured data byte goes into a small FIFO. The FIFO is presented to the downstream ACID key-stream stage over a valid/ready handshake, one byte per accepted transfer: WrData drives the ACID data byte and the ACID compare strobe is active while WrValid and WrReady are both high.

---
 rtl/acid_pkg.sv | 21 ++
 rtl/acid_sync_fifo.sv | 62 ++++++
 rtl/acid_bus_capture.sv | 99 +++++++++
 tb/tb_acid_bus_capture.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/acid_pkg.sv
// acid_pkg: shared constants and FSM encoding
// for the ACID bus capture front end.
package acid_pkg;

  localparam int ACID_FIFO_DEPTH = 4;

  localparam logic [7:0] CRTC_SEL_MASK  = 8'h43;
  localparam logic [7:0] CRTC_SEL_MATCH = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_QUAL = 2'd1,
    ST_HOLD = 2'd2
  } acid_state_e;

  // A14, A9 and A8 low selects the CRTC register-select port.
  function automatic logic crtc_hit(input logic [7:0] a);
    return (a & CRTC_SEL_MASK) == CRTC_SEL_MATCH;
  endfunction

endpackage

// File: rtl/acid_sync_fifo.sv
// acid_sync_fifo: circular buffer FIFO with count.
// A push into a full FIFO is taken only alongside a pop.
module acid_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_pop, do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_pop) rd_d = rd_q + 1'b1;
    if (do_push) wr_d = wr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/acid_bus_capture.sv
// acid_bus_capture: synchronizes the Z80 bus, captures
// OUT writes to &BCxx and queues them for the key stream.
module acid_bus_capture
  import acid_pkg::*;
#(
  parameter int FIFO_DEPTH  = ACID_FIFO_DEPTH,
  parameter int SYNC_STAGES = 2,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          PinCLK,
  input  logic          PinCCLR,
  input  logic [7:0]    PinA,
  input  logic [7:0]    PinD,
  input  logic          PinIORQ_n,
  input  logic          PinWR_n,
  input  logic          PinM1_n,
  output logic [7:0]    WrData,
  output logic          WrValid,
  input  logic          WrReady,
  output logic          Overflow,
  output logic [LW-1:0] Level
);

  logic [SYNC_STAGES-1:0][7:0] a_q, d_q;
  logic [SYNC_STAGES-1:0] iorq_q, wr_q, m1_q;

  always_ff @(posedge PinCLK) begin
    if (!PinCCLR) begin
      a_q    <= '0;
      d_q    <= '0;
      iorq_q <= '1;
      wr_q   <= '1;
      m1_q   <= '1;
    end else begin
      a_q    <= {a_q[SYNC_STAGES-2:0], PinA};
      d_q    <= {d_q[SYNC_STAGES-2:0], PinD};
      iorq_q <= {iorq_q[SYNC_STAGES-2:0], PinIORQ_n};
      wr_q   <= {wr_q[SYNC_STAGES-2:0], PinWR_n};
      m1_q   <= {m1_q[SYNC_STAGES-2:0], PinM1_n};
    end
  end

  logic [7:0] a_s, d_s;
  logic strobe_s, active;

  assign a_s      = a_q[SYNC_STAGES-1];
  assign d_s      = d_q[SYNC_STAGES-1];
  assign strobe_s = !iorq_q[SYNC_STAGES-1]
                 && !wr_q[SYNC_STAGES-1];
  assign active   = strobe_s && m1_q[SYNC_STAGES-1];

  acid_state_e state_q;

  // Two consecutive active samples qualify a bus cycle.
  always_ff @(posedge PinCLK) begin
    if (!PinCCLR) begin
      state_q <= ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (active) state_q <= ST_QUAL;
        ST_QUAL: state_q <= active ? ST_HOLD : ST_IDLE;
        ST_HOLD: if (!strobe_s) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic push, pop, full, empty;

  assign push    = (state_q == ST_QUAL) && active
                && crtc_hit(a_s);
  assign WrValid = !empty;
  assign pop     = WrValid && WrReady;

  acid_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (PinCLK),
    .rst_ni  (PinCCLR),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (d_s),
    .data_o  (WrData),
    .full_o  (full),
    .empty_o (empty),
    .count_o (Level)
  );

  logic ovf_q;

  always_ff @(posedge PinCLK) begin
    if (!PinCCLR) ovf_q <= 1'b0;
    else if (push && full && !pop) ovf_q <= 1'b1;
  end

  assign Overflow = ovf_q;

endmodule

// File: tb/tb_acid_bus_capture.sv
// tb_acid_bus_capture: directed and random bus writes
// checked against a transaction-level queue model.
module tb_acid_bus_capture;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic PinCLK = 1'b0;
  logic PinCCLR, PinIORQ_n, PinWR_n, PinM1_n, WrReady;
  logic [7:0] PinA, PinD, WrData;
  logic WrValid, Overflow;
  logic [LW-1:0] Level;

  acid_bus_capture #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .PinCLK    (PinCLK),
    .PinCCLR   (PinCCLR),
    .PinA      (PinA),
    .PinD      (PinD),
    .PinIORQ_n (PinIORQ_n),
    .PinWR_n   (PinWR_n),
    .PinM1_n   (PinM1_n),
    .WrData    (WrData),
    .WrValid   (WrValid),
    .WrReady   (WrReady),
    .Overflow  (Overflow),
    .Level     (Level)
  );

  always #5 PinCLK = ~PinCLK;

  typedef struct {
    int          edge_no;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          norm;
    int          len;
  } txn_t;

  typedef struct {
    int         edge_no;
    logic [7:0] data;
  } pop_t;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   vcnt = 0;
  bit   cmp_en = 0;
  bit   rand_rdy = 0;
  int   rdy_pct = 50;
  txn_t sched[$];
  pop_t plog[$];
  logic [7:0] mq[$];
  bit   m_ovf = 0;

  // Model: each bus write is judged as a whole transaction.
  always @(posedge PinCLK) begin
    bit   popv, pushv;
    int   sz;
    txn_t t;
    cyc = cyc + 1;
    if (WrValid === 1'b1 && WrReady === 1'b1)
      plog.push_back('{cyc, WrData});
    if (!PinCCLR) begin
      mq.delete();
      m_ovf = 0;
      sched.delete();
    end else begin
      popv  = (mq.size() != 0) && (WrReady == 1'b1);
      pushv = 0;
      while (sched.size() != 0 && sched[0].edge_no < cyc)
        void'(sched.pop_front());
      if (sched.size() != 0 && sched[0].edge_no == cyc) begin
        t = sched.pop_front();
        pushv = t.norm && t.len >= 2 && !t.addr[14]
             && !t.addr[9] && !t.addr[8];
      end
      sz = mq.size();
      if (popv) void'(mq.pop_front());
      if (pushv) begin
        if (sz < DEPTH || popv) mq.push_back(t.data);
        else m_ovf = 1;
      end
    end
  end

  always @(negedge PinCLK) begin
    logic [7:0] ed;
    if (cmp_en) begin
      ed = (mq.size() != 0) ? mq[0] : 8'h00;
      tests++;
      if (WrValid !== (mq.size() != 0) || WrData !== ed
          || Level !== LW'(mq.size()) || Overflow !== m_ovf) begin
        fails++;
        $display("FAIL model cyc=%0d got v=%b d=%h l=%0d o=%b exp v=%b d=%h l=%0d o=%b",
                 cyc, WrValid, WrData, Level, Overflow,
                 mq.size() != 0, ed, mq.size(), m_ovf);
      end
      if (WrValid === 1'b1) vcnt++;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge PinCLK);
    if (rand_rdy) WrReady = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic bus_write(input logic [15:0] addr,
                           input logic [7:0] d,
                           input bit norm,
                           input int len,
                           input int gap,
                           input int pulse_at);
    txn_t t;
    PinA      = addr[15:8];
    PinD      = d;
    PinM1_n   = norm;
    PinIORQ_n = 1'b0;
    PinWR_n   = 1'b0;
    t.edge_no = cyc + 1 + SYNC + 1;
    t.addr    = addr;
    t.data    = d;
    t.norm    = norm;
    t.len     = len;
    sched.push_back(t);
    for (int i = 0; i < len; i++) begin
      if (i == pulse_at) WrReady = 1'b1;
      step();
      if (i == pulse_at) WrReady = 1'b0;
    end
    PinIORQ_n = 1'b1;
    PinWR_n   = 1'b1;
    PinM1_n   = 1'b1;
    for (int i = 0; i < gap; i++) begin
      PinA = 8'($urandom);
      PinD = 8'($urandom);
      step();
    end
  endtask

  task automatic do_reset();
    PinCCLR = 1'b0;
    step();
    PinCCLR = 1'b1;
  endtask

  initial begin
    int c0, v0;
    logic [7:0] bp [5];
    logic [15:0] a;
    bp = '{8'hFF, 8'h00, 8'hFF, 8'h77, 8'hB3};

    PinCCLR   = 1'b0;
    PinA      = 8'hBC;
    PinD      = 8'hAA;
    PinIORQ_n = 1'b0;
    PinWR_n   = 1'b0;
    PinM1_n   = 1'b1;
    WrReady   = 1'b0;
    cmp_en    = 1;
    repeat (3) begin
      @(negedge PinCLK);
      chk("rst_valid", WrValid, 0);
      chk("rst_data", WrData, 8'h00);
      chk("rst_level", Level, 0);
      chk("rst_ovf", Overflow, 0);
    end
    PinCCLR   = 1'b1;
    PinIORQ_n = 1'b1;
    PinWR_n   = 1'b1;
    repeat (4) step();
    chk("post_rst_level", Level, 0);

    WrReady = 1'b1;
    plog.delete();
    c0 = cyc;
    v0 = vcnt;
    bus_write(16'hBC00, 8'hFF, 1, 6, 3, -1);
    chk("single_pops", plog.size(), 1);
    if (plog.size() > 0) begin
      chk("single_data", plog[0].data, 8'hFF);
      chk("single_pop_edge", plog[0].edge_no - c0, 5);
    end
    chk("single_valid_cycles", vcnt - v0, 1);

    plog.delete();
    bus_write(16'hBD00, 8'h11, 1, 4, 3, -1);
    bus_write(16'h7F00, 8'h22, 1, 4, 3, -1);
    bus_write(16'hFC00, 8'h33, 1, 4, 3, -1);
    bus_write(16'hBC00, 8'h44, 0, 4, 3, -1);
    bus_write(16'hBC00, 8'h55, 1, 1, 4, -1);
    chk("decode_pops", plog.size(), 0);
    chk("decode_level", Level, 0);

    WrReady = 1'b0;
    for (int i = 0; i < 5; i++)
      bus_write(16'hBC00, bp[i], 1, 4, 2, -1);
    chk("bp_level", Level, 4);
    chk("bp_ovf", Overflow, 1);
    chk("bp_head", WrData, 8'hFF);
    plog.delete();
    WrReady = 1'b1;
    repeat (8) step();
    WrReady = 1'b0;
    chk("bp_pops", plog.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < plog.size()) chk("bp_order", plog[i].data, bp[i]);
    chk("bp_drained", Level, 0);

    do_reset();
    chk("clr_ovf", Overflow, 0);
    bus_write(16'hBC00, 8'h11, 1, 4, 2, -1);
    bus_write(16'hBC00, 8'h22, 1, 4, 2, -1);
    bus_write(16'hBC00, 8'h33, 1, 4, 2, -1);
    bus_write(16'hBC00, 8'h44, 1, 4, 2, -1);
    chk("sim_full", Level, 4);
    plog.delete();
    bus_write(16'hBC00, 8'h55, 1, 6, 2, 3);
    chk("sim_level", Level, 4);
    chk("sim_ovf", Overflow, 0);
    chk("sim_head", WrData, 8'h22);
    chk("sim_pops", plog.size(), 1);

    do_reset();
    bus_write(16'hBC00, 8'hA1, 1, 4, 2, -1);
    bus_write(16'hBC00, 8'hA2, 1, 4, 2, -1);
    bus_write(16'hBC00, 8'hA3, 1, 4, 2, -1);
    chk("mid_queued", Level, 3);
    do_reset();
    chk("mid_level", Level, 0);
    chk("mid_valid", WrValid, 0);
    WrReady = 1'b1;
    plog.delete();
    bus_write(16'hBC00, 8'h5A, 1, 4, 4, -1);
    chk("mid_next_pops", plog.size(), 1);
    if (plog.size() > 0) chk("mid_next_data", plog[0].data, 8'h5A);

    rand_rdy = 1;
    for (int p = 0; p < 2; p++) begin
      rdy_pct = (p == 0) ? 60 : 15;
      for (int n = 0; n < 150; n++) begin
        a = 16'($urandom);
        if ($urandom_range(0, 1) == 1) a = a & ~16'h4300;
        bus_write(a, 8'($urandom), $urandom_range(0, 9) != 0,
                  $urandom_range(1, 6), $urandom_range(1, 4), -1);
      end
    end
    rand_rdy = 0;
    WrReady  = 1'b1;
    repeat (12) step();
    chk("rand_drained", Level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
